// File: rtl/minimac_pkg.sv
// minimac_pkg
//   Shared definitions for the minimac receive DMA path: FSM state encoding,
//   byte-lane select constants, default parameters and the layout of one
//   word-FIFO entry (30-bit word address, 32-bit data, 4-bit lane select).
package minimac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_DROP  = 2'd2,
    ST_FLUSH = 2'd3
  } rx_state_t;

  localparam int MAX_BYTES_DEFAULT       = 1530;
  localparam int FIFO_DEPTH_LOG2_DEFAULT = 3;

  // Lanes are big-endian: the first byte of a word lands in bits 31:24.
  localparam logic [3:0] SEL_LANE0   = 4'b1000;
  localparam logic [3:0] SEL_LANE01  = 4'b1100;
  localparam logic [3:0] SEL_LANE012 = 4'b1110;
  localparam logic [3:0] SEL_ALL     = 4'b1111;

  localparam int ENTRY_W = 66;

  typedef struct packed {
    logic [29:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
  } wr_entry_t;

  // Byte enables for a partially filled word holding lanes_filled bytes.
  function automatic logic [3:0] partial_sel(input logic [1:0] lanes_filled);
    logic [3:0] sel;
    case (lanes_filled)
      2'd1:    sel = SEL_LANE0;
      2'd2:    sel = SEL_LANE01;
      2'd3:    sel = SEL_LANE012;
      default: sel = SEL_ALL;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/minimac_rxwfifo.sv
// minimac_rxwfifo
//   Synchronous show-ahead FIFO holding packed write requests for the RX DMA.
//   dout always presents the oldest entry; pop discards it.
// Ports:
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   flush              : synchronous clear to empty (wins over push/pop)
//   push, din          : write an entry (accepted when not full, or when a pop
//                        frees a slot in the same cycle)
//   pop                : discard the head entry
//   dout               : head entry
//   full, empty        : occupancy flags
module minimac_rxwfifo #(
  parameter int DEPTH_LOG2 = 3,
  parameter int WIDTH      = 66
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2+1)'(DEPTH);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  do_push, do_pop;

  assign full    = (count == DEPTH_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A full FIFO can still take a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; only the pointers define validity.
  always_ff @(posedge sys_clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/minimac_rxdma.sv
// minimac_rxdma
//   Receive DMA of the minimac MAC. Packs framer bytes big-endian into 32-bit
//   words and writes them through a Wishbone master into the RX slot chosen by
//   the control interface, reporting progress with single-cycle pulses.
// Ports:
//   sys_clk, sys_rst_n        : clock, asynchronous active-low reset
//   rx_rst                    : synchronous soft reset / cycle abort
//   rx_valid, rx_adr          : slot loaded flag and slot word address
//   rx_resetcount/incrcount   : clear / increment the slot byte count
//   rx_endframe               : frame fully written
//   fifo_full                 : word FIFO overflow, frame dropped
//   rxb_data/stb/sof/eof/err  : byte stream from the RX framer
//   wbm_*                     : Wishbone write master
module minimac_rxdma
  import minimac_pkg::*;
#(
  parameter int FIFO_DEPTH_LOG2 = FIFO_DEPTH_LOG2_DEFAULT,
  parameter int MAX_BYTES       = MAX_BYTES_DEFAULT
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        rx_rst,
  input  logic        rx_valid,
  input  logic [29:0] rx_adr,
  output logic        rx_resetcount,
  output logic        rx_incrcount,
  output logic        rx_endframe,
  output logic        fifo_full,
  input  logic [7:0]  rxb_data,
  input  logic        rxb_stb,
  input  logic        rxb_sof,
  input  logic        rxb_eof,
  input  logic        rxb_err,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  input  logic        wbm_ack_i
);

  localparam logic [10:0] MAX_CNT = 11'(MAX_BYTES);

  rx_state_t   state, state_d;
  logic [29:0] base, base_d;
  logic [8:0]  word_ofs, word_ofs_d;
  logic [31:0] word, word_d;
  logic [1:0]  lane, lane_d;
  logic [10:0] byte_cnt, byte_cnt_d;
  logic        drop_pend, drop_pend_d;
  logic        resetcount_d, incrcount_d, endframe_d, overflow_d;
  logic        start_frame, push_req, push, pop;
  wr_entry_t   push_entry, head;
  logic        q_full, q_empty;

  assign wbm_we_o = 1'b1;
  assign pop      = wbm_cyc_o && wbm_ack_i;
  assign push     = push_req && !overflow_d;

  minimac_rxwfifo #(
    .DEPTH_LOG2(FIFO_DEPTH_LOG2),
    .WIDTH     (ENTRY_W)
  ) u_wfifo (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .flush    (rx_rst),
    .push     (push),
    .din      (push_entry),
    .pop      (pop),
    .dout     (head),
    .full     (q_full),
    .empty    (q_empty)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= ST_IDLE;
    else            state <= state_d;
  end

  always_comb begin
    state_d      = state;
    base_d       = base;
    word_ofs_d   = word_ofs;
    word_d       = word;
    lane_d       = lane;
    byte_cnt_d   = byte_cnt;
    drop_pend_d  = drop_pend;
    resetcount_d = 1'b0;
    incrcount_d  = 1'b0;
    endframe_d   = 1'b0;
    overflow_d   = 1'b0;
    start_frame  = 1'b0;
    push_req     = 1'b0;
    push_entry.adr = base + 30'(word_ofs);
    push_entry.dat = word;
    push_entry.sel = SEL_ALL;

    if (rx_rst) begin
      state_d     = ST_IDLE;
      word_d      = '0;
      lane_d      = '0;
      byte_cnt_d  = '0;
      drop_pend_d = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rxb_stb && rxb_sof) start_frame = 1'b1;
        end
        ST_RECV: begin
          if (rxb_stb && rxb_sof) begin
            // Missing eof: abandon the current frame, then start afresh.
            resetcount_d = 1'b1;
            start_frame  = 1'b1;
          end else if (rxb_eof) begin
            if (rxb_err) begin
              resetcount_d = 1'b1;
              state_d      = ST_IDLE;
            end else begin
              if (lane != 2'd0) begin
                push_req       = 1'b1;
                push_entry.sel = partial_sel(lane);
              end
              state_d = ST_FLUSH;
            end
            word_d = '0;
            lane_d = '0;
          end else if (rxb_stb) begin
            if (byte_cnt >= MAX_CNT) begin
              resetcount_d = 1'b1;
              state_d      = ST_DROP;
              word_d       = '0;
              lane_d       = '0;
            end else begin
              byte_cnt_d  = byte_cnt + 11'd1;
              incrcount_d = 1'b1;
              case (lane)
                2'd0:    word_d[31:24] = rxb_data;
                2'd1:    word_d[23:16] = rxb_data;
                2'd2:    word_d[15:8]  = rxb_data;
                default: word_d[7:0]   = rxb_data;
              endcase
              lane_d = lane + 2'd1;
              if (lane == 2'd3) begin
                push_req       = 1'b1;
                push_entry.dat = word_d;
                word_ofs_d     = word_ofs + 9'd1;
                word_d         = '0;
              end
            end
          end
        end
        ST_DROP: begin
          if (rxb_eof) state_d = ST_IDLE;
        end
        default: begin
          // A frame arriving while the previous one drains cannot be stored;
          // remember it so its bytes are skipped up to its own eof.
          if (rxb_stb && rxb_sof) drop_pend_d = 1'b1;
          else if (rxb_eof)       drop_pend_d = 1'b0;
          if (q_empty && !wbm_cyc_o) begin
            endframe_d  = 1'b1;
            state_d     = drop_pend_d ? ST_DROP : ST_IDLE;
            drop_pend_d = 1'b0;
          end
        end
      endcase

      if (start_frame) begin
        if (rx_valid) begin
          base_d       = rx_adr;
          word_ofs_d   = '0;
          word_d       = {rxb_data, 24'h0};
          lane_d       = 2'd1;
          byte_cnt_d   = 11'd1;
          resetcount_d = 1'b1;
          incrcount_d  = 1'b1;
          state_d      = ST_RECV;
        end else begin
          word_d     = '0;
          lane_d     = '0;
          byte_cnt_d = '0;
          state_d    = ST_DROP;
        end
      end

      // Overflow drops the word and the rest of the frame; a simultaneous pop
      // frees a slot, so that case is a normal push.
      if (push_req && q_full && !pop) begin
        overflow_d = 1'b1;
        state_d    = ST_DROP;
        word_d     = '0;
        lane_d     = '0;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      base          <= '0;
      word_ofs      <= '0;
      word          <= '0;
      lane          <= '0;
      byte_cnt      <= '0;
      drop_pend     <= 1'b0;
      rx_resetcount <= 1'b0;
      rx_incrcount  <= 1'b0;
      rx_endframe   <= 1'b0;
      fifo_full     <= 1'b0;
    end else begin
      base          <= base_d;
      word_ofs      <= word_ofs_d;
      word          <= word_d;
      lane          <= lane_d;
      byte_cnt      <= byte_cnt_d;
      drop_pend     <= drop_pend_d;
      rx_resetcount <= resetcount_d;
      rx_incrcount  <= incrcount_d;
      rx_endframe   <= endframe_d;
      fifo_full     <= overflow_d;
    end
  end

  // Single outstanding write: the head entry is copied into the output
  // registers when a cycle starts and held until ack, which also pops it.
  // The idle cycle after ack lets the FIFO head advance before the next start.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      wbm_sel_o <= '0;
    end else if (rx_rst) begin
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
    end else if (wbm_cyc_o) begin
      if (wbm_ack_i) begin
        wbm_cyc_o <= 1'b0;
        wbm_stb_o <= 1'b0;
      end
    end else if (!q_empty) begin
      wbm_cyc_o <= 1'b1;
      wbm_stb_o <= 1'b1;
      wbm_adr_o <= {head.adr, 2'b00};
      wbm_dat_o <= head.dat;
      wbm_sel_o <= head.sel;
    end
  end

endmodule

// File: tb/tb_minimac_rxdma.sv
// tb_minimac_rxdma
//   Randomized bench for minimac_rxdma. Frames of random bytes are driven into
//   the framer interface; a random-latency Wishbone slave logs every write.
//   Expected writes and pulse counts are computed from the frame contents by
//   plain arithmetic (word i holds bytes 4i..4i+3 at slot address base+i).
module tb_minimac_rxdma;

  logic        sys_clk   = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        rx_rst    = 1'b0;
  logic        rx_valid  = 1'b0;
  logic [29:0] rx_adr    = '0;
  logic [7:0]  rxb_data  = '0;
  logic        rxb_stb   = 1'b0;
  logic        rxb_sof   = 1'b0;
  logic        rxb_eof   = 1'b0;
  logic        rxb_err   = 1'b0;
  logic        wbm_ack_i = 1'b0;
  logic        rx_resetcount, rx_incrcount, rx_endframe, fifo_full;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;

  always #5 sys_clk = ~sys_clk;

  minimac_rxdma dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .rx_rst       (rx_rst),
    .rx_valid     (rx_valid),
    .rx_adr       (rx_adr),
    .rx_resetcount(rx_resetcount),
    .rx_incrcount (rx_incrcount),
    .rx_endframe  (rx_endframe),
    .fifo_full    (fifo_full),
    .rxb_data     (rxb_data),
    .rxb_stb      (rxb_stb),
    .rxb_sof      (rxb_sof),
    .rxb_eof      (rxb_eof),
    .rxb_err      (rxb_err),
    .wbm_adr_o    (wbm_adr_o),
    .wbm_dat_o    (wbm_dat_o),
    .wbm_sel_o    (wbm_sel_o),
    .wbm_cyc_o    (wbm_cyc_o),
    .wbm_stb_o    (wbm_stb_o),
    .wbm_we_o     (wbm_we_o),
    .wbm_ack_i    (wbm_ack_i)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cycle    = 0;

  always @(posedge sys_clk) cycle <= cycle + 1;

  // Observed activity since the last clear_monitor.
  int         cnt_reset, cnt_incr, cnt_end, cnt_full;
  int         end_cycle, last_ack_cycle;
  logic [67:0] obs_wr[$];
  bit         ack_hold = 1'b0;
  bit         ack_fast = 1'b0;
  logic [7:0] frame_bytes[$];

  // Pulse counting and the Wishbone slave both work on the falling edge,
  // where DUT outputs are settled; ack is presented for the next rising edge.
  always @(negedge sys_clk) begin
    if (rx_resetcount) cnt_reset++;
    if (rx_incrcount)  cnt_incr++;
    if (fifo_full)     cnt_full++;
    if (rx_endframe) begin
      cnt_end++;
      end_cycle = cycle;
    end
    if (wbm_cyc_o && wbm_stb_o && !wbm_ack_i && !ack_hold &&
        (ack_fast || $urandom_range(0, 1) == 0)) begin
      wbm_ack_i = 1'b1;
      obs_wr.push_back({wbm_adr_o, wbm_dat_o, wbm_sel_o});
      last_ack_cycle = cycle;
    end else begin
      wbm_ack_i = 1'b0;
    end
  end

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_monitor();
    @(posedge sys_clk);
    cnt_reset = 0;
    cnt_incr  = 0;
    cnt_end   = 0;
    cnt_full  = 0;
    end_cycle = 0;
    last_ack_cycle = 0;
    obs_wr.delete();
    @(negedge sys_clk);
  endtask

  task automatic send_byte(input logic [7:0] d, input bit sof, input int max_gap);
    repeat ($urandom_range(0, max_gap)) @(negedge sys_clk);
    rxb_data = d;
    rxb_stb  = 1'b1;
    rxb_sof  = sof;
    @(negedge sys_clk);
    rxb_stb  = 1'b0;
    rxb_sof  = 1'b0;
  endtask

  task automatic send_eof(input bit err);
    rxb_eof = 1'b1;
    rxb_err = err;
    @(negedge sys_clk);
    rxb_eof = 1'b0;
    rxb_err = 1'b0;
  endtask

  task automatic applyStimulus(input int len, input logic [29:0] adr, input bit valid,
                               input bit err, input int max_gap);
    logic [7:0] b;
    rx_valid = valid;
    rx_adr   = adr;
    frame_bytes.delete();
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom);
      frame_bytes.push_back(b);
      send_byte(b, i == 0, max_gap);
    end
    send_eof(err);
  endtask

  // Wait until the bus has been idle for a while, bounded.
  task automatic drain();
    int quiet  = 0;
    int waited = 0;
    while (quiet < 30 && waited < 8000) begin
      @(negedge sys_clk);
      waited++;
      quiet = wbm_cyc_o ? 0 : quiet + 1;
    end
    if (quiet < 30) checkOutput("drain_timeout", 128'(waited), 128'(0));
  endtask

  // Word i carries frame bytes 4i..4i+3, first byte in the top lane, written
  // to byte address 4*(base+i) with the slot address wrapping at 2^30 words.
  task automatic check_writes(input string tag, input logic [29:0] base,
                              input int nwords, input int nbytes);
    logic [31:0] d;
    logic [3:0]  s;
    logic [29:0] wa;
    checkOutput({tag, "_nwr"}, 128'(obs_wr.size()), 128'(nwords));
    for (int i = 0; i < nwords && i < obs_wr.size(); i++) begin
      d  = '0;
      s  = '0;
      wa = base + 30'(i);
      for (int k = 0; k < 4; k++) begin
        if (4 * i + k < nbytes) begin
          d = d | (32'(frame_bytes[4 * i + k]) << (8 * (3 - k)));
          s[3 - k] = 1'b1;
        end
      end
      checkOutput($sformatf("%s_wr%0d", tag, i), 128'(obs_wr[i]), 128'({wa, 2'b00, d, s}));
    end
  endtask

  // good: all n bytes written, final word may be partial, one endframe.
  // otherwise: frame aborted after n stored bytes; only complete words made it
  // out, the slot count is cleared at start and again at the abort.
  task automatic expect_frame(input string tag, input logic [29:0] base, input int n, input bit good);
    if (good) begin
      check_writes(tag, base, (n + 3) / 4, n);
      checkOutput({tag, "_reset"}, 128'(cnt_reset), 128'(1));
      checkOutput({tag, "_end"}, 128'(cnt_end), 128'(1));
      checkOutput({tag, "_end_after_ack"}, 128'(end_cycle > last_ack_cycle), 128'(1));
    end else begin
      check_writes(tag, base, n / 4, (n / 4) * 4);
      checkOutput({tag, "_reset"}, 128'(cnt_reset), 128'(2));
      checkOutput({tag, "_end"}, 128'(cnt_end), 128'(0));
    end
    checkOutput({tag, "_incr"}, 128'(cnt_incr), 128'(n));
    checkOutput({tag, "_full"}, 128'(cnt_full), 128'(0));
  endtask

  task automatic expect_silent(input string tag);
    checkOutput({tag, "_nwr"}, 128'(obs_wr.size()), 128'(0));
    checkOutput({tag, "_reset"}, 128'(cnt_reset), 128'(0));
    checkOutput({tag, "_incr"}, 128'(cnt_incr), 128'(0));
    checkOutput({tag, "_end"}, 128'(cnt_end), 128'(0));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cycle);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [29:0] adr;
    int          len;
    bit          valid, err;
    int          waited;

    repeat (3) @(negedge sys_clk);
    checkOutput("rst_cyc", 128'(wbm_cyc_o), 128'(0));
    checkOutput("rst_stb", 128'(wbm_stb_o), 128'(0));
    checkOutput("rst_we", 128'(wbm_we_o), 128'(1));
    checkOutput("rst_adr", 128'(wbm_adr_o), 128'(0));
    checkOutput("rst_dat", 128'(wbm_dat_o), 128'(0));
    checkOutput("rst_sel", 128'(wbm_sel_o), 128'(0));
    checkOutput("rst_pulses", 128'({rx_resetcount, rx_incrcount, rx_endframe, fifo_full}), 128'(0));
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);

    $display("[TB] 64-byte frame at slot 0x100");
    clear_monitor();
    applyStimulus(64, 30'h100, 1'b1, 1'b0, 1);
    drain();
    expect_frame("f64", 30'h100, 64, 1'b1);

    $display("[TB] 61-byte frame at slot 0x100");
    clear_monitor();
    applyStimulus(61, 30'h100, 1'b1, 1'b0, 1);
    drain();
    expect_frame("f61", 30'h100, 61, 1'b1);

    $display("[TB] errored frame after 10 bytes");
    clear_monitor();
    applyStimulus(10, 30'h2000, 1'b1, 1'b1, 1);
    drain();
    expect_frame("ferr", 30'h2000, 10, 1'b0);

    $display("[TB] frame with no slot loaded");
    clear_monitor();
    applyStimulus(30, 30'h300, 1'b0, 1'b0, 1);
    drain();
    expect_silent("noslot");

    $display("[TB] ack stalled during 100-byte frame");
    clear_monitor();
    ack_hold = 1'b1;
    fork
      applyStimulus(100, 30'h500, 1'b1, 1'b0, 1);
      begin
        repeat (200) @(negedge sys_clk);
        ack_hold = 1'b0;
      end
    join
    drain();
    check_writes("ovf", 30'h500, 8, 32);
    checkOutput("ovf_full", 128'(cnt_full), 128'(1));
    checkOutput("ovf_end", 128'(cnt_end), 128'(0));
    rx_rst = 1'b1;
    @(negedge sys_clk);
    rx_rst = 1'b0;

    $display("[TB] soft reset with a write in flight");
    clear_monitor();
    ack_hold = 1'b1;
    rx_valid = 1'b1;
    rx_adr   = 30'h700;
    for (int i = 0; i < 20; i++) send_byte(8'($urandom), i == 0, 0);
    waited = 0;
    while (!wbm_cyc_o && waited < 50) begin
      @(negedge sys_clk);
      waited++;
    end
    checkOutput("rst_mid_cyc_before", 128'(wbm_cyc_o), 128'(1));
    rx_rst = 1'b1;
    @(negedge sys_clk);
    rx_rst = 1'b0;
    checkOutput("rst_mid_cyc_after", 128'(wbm_cyc_o), 128'(0));
    checkOutput("rst_mid_stb_after", 128'(wbm_stb_o), 128'(0));
    clear_monitor();
    for (int i = 0; i < 20; i++) send_byte(8'($urandom), 1'b0, 0);
    send_eof(1'b0);
    ack_hold = 1'b0;
    drain();
    expect_silent("rst_mid");

    clear_monitor();
    applyStimulus(23, 30'h740, 1'b1, 1'b0, 2);
    drain();
    expect_frame("post_rst", 30'h740, 23, 1'b1);

    $display("[TB] oversize 1531-byte frame");
    clear_monitor();
    ack_fast = 1'b1;
    applyStimulus(1531, 30'h1000, 1'b1, 1'b0, 0);
    drain();
    ack_fast = 1'b0;
    expect_frame("big", 30'h1000, 1530, 1'b0);

    $display("[TB] random frames");
    for (int f = 0; f < 10; f++) begin
      len   = $urandom_range(1, 70);
      adr   = (f == 0) ? 30'h3FFF_FFFC : 30'($urandom);
      valid = ($urandom_range(0, 5) != 0);
      err   = ($urandom_range(0, 3) == 0);
      clear_monitor();
      applyStimulus(len, adr, valid, err, 3);
      drain();
      if (!valid) expect_silent($sformatf("rnd%0d", f));
      else        expect_frame($sformatf("rnd%0d", f), adr, len, !err);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
